uart_tx_arb: RTL

- Round-robin, packet-locked arbiter that shares the single UART transmitter byte interface (tx_d / tx_d_valid / ready) among NREQ byte-stream requesters, e.g. CSR writes, a DMA channel and a debug console.
- Sits between the requesters and the UART transmitter's byte input.
- A grant is held until the requester's last byte is sent, a burst limit is reached, or the requester stalls past a timeout.

---
 rtl/uart_tx_arb_pkg.sv | 49 ++++
 rtl/uart_tx_arb_picker.sv | 32 +++
 rtl/uart_tx_arb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_defs (package)
//  Description : Shared types and helpers for the UART transmit arbiter and
//                future UART byte-stream muxing blocks.
//                - ArbState_t : arbiter FSM encoding
//                - pick_t     : result of a round-robin pick (found + index)
//                - rr_pick()  : circular priority scan over up to 8 requesters
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

    // Largest requester count the shared picker supports (index fits 3 bits).
    localparam int unsigned c_MAX_REQ = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } ArbState_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scan mask upward starting at ptr+1, wrapping at nreq. The candidate is
    // folded back into range with a single subtraction since ptr < nreq and
    // k <= nreq guarantee ptr+k < 2*nreq.
    function automatic pick_t rr_pick(input logic [7:0] mask,
                                      input logic [2:0] ptr,
                                      input logic [3:0] nreq);
        pick_t      res;
        logic [3:0] cand;
        res = '0;
        for (int k = 1; k <= 8; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= nreq) begin
                cand = cand - nreq;
            end
            if ((4'(k) <= nreq) && !res.found && mask[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_picker.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_picker
//  Description : Combinational circular priority encoder. Returns the first
//                set bit of mask scanning upward from ptr+1 with wraparound.
//  Ports       : mask  [NREQ-1:0]        in  candidate requesters
//                ptr   [$clog2(NREQ)-1:0] in  last winner (lowest priority)
//                idx   [$clog2(NREQ)-1:0] out selected requester
//                found                    out at least one candidate present
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker
    import uart_defs::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         mask,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);

    localparam int IW = $clog2(NREQ);

    pick_t w_pick;

    assign w_pick = rr_pick(8'(mask), 3'(ptr), 4'(NREQ));
    assign idx    = IW'(w_pick.idx);
    assign found  = w_pick.found;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Round-robin, packet-locked arbiter sharing one UART
//                transmitter byte interface among NREQ byte-stream requesters.
//                A grant is held until the last byte of a packet, MAX_BURST
//                bytes, or TIMEOUT idle cycles of the granted requester.
//  Ports       : clk, rst (sync, active-high)
//                req_en_i / req_d_i / req_valid_i / req_last_i / req_ready_o :
//                    per-requester byte streams (byte i at [8i+7:8i])
//                tx_d_o / tx_d_valid_o / tx_d_ready_i : transmitter byte port
//                grant_o (one-hot), busy_o, timeout_o (pulse), timeout_id_o
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_defs::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_en_i,
    input  logic [NREQ*8-1:0]       req_d_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ-1:0]         req_last_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic [7:0]              tx_d_o,
    output logic                    tx_d_valid_o,
    input  logic                    tx_d_ready_i,
    output logic [NREQ-1:0]         grant_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic [$clog2(NREQ)-1:0] timeout_id_o
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0]   c_RR_INIT    = IW'(NREQ - 1);
    localparam logic [BW-1:0]   c_BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0]   c_BURST_MAX  = BW'(MAX_BURST);
    localparam logic [CW-1:0]   c_IDLE_LAST  = CW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] c_ONE        = NREQ'(1);

    ArbState_t       r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_rr_ptr;
    logic [BW-1:0]   r_burst_cnt;
    logic [CW-1:0]   r_idle_cnt;
    logic            r_timeout;
    logic [IW-1:0]   r_timeout_id;

    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_found;
    logic            w_busy;
    logic            w_gvalid;
    logic            w_hs;
    logic            w_last;

    uart_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .mask  (req_valid_i & req_en_i),
        .ptr   (r_rr_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_busy   = (r_state == GRANT);
    assign w_gvalid = w_busy & req_valid_i[r_gidx];
    assign w_hs     = w_gvalid & tx_d_ready_i;
    assign w_last   = req_last_i[r_gidx];

    // Zero-latency pass-through of the granted requester; everything is
    // quiet while idle so tx_d_valid_o can never assert without a grant.
    always_comb begin
        tx_d_o       = '0;
        tx_d_valid_o = 1'b0;
        req_ready_o  = '0;
        if (w_busy) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_gidx == IW'(i)) begin
                    tx_d_o = req_d_i[i*8 +: 8];
                end
            end
            tx_d_valid_o        = req_valid_i[r_gidx];
            req_ready_o[r_gidx] = tx_d_ready_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_rr_ptr     <= c_RR_INIT;
            r_burst_cnt  <= '0;
            r_idle_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_state     <= GRANT;
                        r_grant     <= c_ONE << w_pick_idx;
                        r_gidx      <= w_pick_idx;
                        r_rr_ptr    <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                    end
                end
                GRANT: begin
                    // A ready-low stall (valid high, no handshake) touches
                    // neither counter, so a slow transmitter never times out.
                    if (w_hs) begin
                        if (r_burst_cnt != c_BURST_MAX) begin
                            r_burst_cnt <= r_burst_cnt + BW'(1);
                        end
                        r_idle_cnt <= '0;
                        if (w_last || (r_burst_cnt == c_BURST_LAST)) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                        end
                    end else if (!w_gvalid) begin
                        if (r_idle_cnt == c_IDLE_LAST) begin
                            r_state      <= IDLE;
                            r_grant      <= '0;
                            r_timeout    <= 1'b1;
                            r_timeout_id <= r_gidx;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant_o      = r_grant;
    assign busy_o       = w_busy;
    assign timeout_o    = r_timeout;
    assign timeout_id_o = r_timeout_id;

endmodule
`default_nettype wire
